// File: rtl/screen_sequencer.sv
// Frame-synchronous OLED screen selector (title/ctrl1/ctrl2/play/over) with post-switch blanking; switches land on frame_begin.
// Define SCREEN_ATTRACT_EN to add the title idle timeout (attract mode into CTRL1 and back).
module screen_sequencer #(
  parameter int unsigned BLANK_FRAMES    = 2,
  parameter int unsigned GAMEOVER_FRAMES = 180,
  parameter int unsigned IDLE_FRAMES     = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_begin,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_centre,
  input  logic       game_over,
  output logic [2:0] screen_sel,
  output logic       blank,
  output logic       screen_changed,
  output logic       play_active
);

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_CTRL1 = 3'd1,
    S_CTRL2 = 3'd2,
    S_PLAY  = 3'd3,
    S_OVER  = 3'd4
  } screen_e;

  localparam logic [7:0] BLANK_LOAD = (BLANK_FRAMES == 0) ? 8'd0 : 8'(BLANK_FRAMES - 1);
  localparam logic [9:0] GO_LIM     = 10'(GAMEOVER_FRAMES);
  localparam logic [9:0] CNT_MAX    = 10'h3FF;

  if (BLANK_FRAMES > 255 || GAMEOVER_FRAMES < 1 || GAMEOVER_FRAMES > 1023 ||
      IDLE_FRAMES < 1 || IDLE_FRAMES > 1023) begin : g_bad_param
    $error("screen_sequencer: parameter out of legal range");
  end

  screen_e    sel_q, sel_d, tgt_q, req_tgt;
  logic       pend_q, blank_q, blank_d, changed_q, play_q;
  logic [7:0] blank_cnt_q;
  logic [9:0] go_cnt_q;
  logic [2:0] btn_q, btn_now, rise;
  logic       req, apply;

`ifdef SCREEN_ATTRACT_EN
  localparam logic [9:0] IDLE_LIM = 10'(IDLE_FRAMES);
  logic [9:0] idle_q;
  logic       att_q, att_pend_q, req_att;
`endif

  // bit 2 = centre, 1 = right, 0 = left
  assign btn_now = {btn_centre, btn_right, btn_left};
  assign rise    = btn_now & ~btn_q;
  // pend_q is only ever high after the accept cycle, so this frame_begin is strictly later
  assign apply   = pend_q & frame_begin;

  always_comb begin
    req     = 1'b0;
    req_tgt = S_TITLE;
`ifdef SCREEN_ATTRACT_EN
    req_att = 1'b0;
`endif
    if (!pend_q && !blank_q) begin
      case (sel_q)
        S_TITLE: if (rise[2]) begin req = 1'b1; req_tgt = S_CTRL1; end
        S_CTRL1: begin
          if (rise[2])      begin req = 1'b1; req_tgt = S_PLAY;  end
          else if (rise[1]) begin req = 1'b1; req_tgt = S_CTRL2; end
          else if (rise[0]) begin req = 1'b1; req_tgt = S_TITLE; end
        end
        S_CTRL2: begin
          if (rise[2])      begin req = 1'b1; req_tgt = S_PLAY;  end
          else if (rise[0]) begin req = 1'b1; req_tgt = S_CTRL1; end
        end
        S_PLAY:  if (game_over) begin req = 1'b1; req_tgt = S_OVER; end
        S_OVER:  if (rise[2] || go_cnt_q >= GO_LIM) begin req = 1'b1; req_tgt = S_TITLE; end
        default: ;
      endcase
`ifdef SCREEN_ATTRACT_EN
      if (!req && rise == 3'b000 && idle_q >= IDLE_LIM) begin
        if (sel_q == S_TITLE) begin
          req     = 1'b1;
          req_tgt = S_CTRL1;
          req_att = 1'b1;
        end else if (att_q && (sel_q == S_CTRL1 || sel_q == S_CTRL2)) begin
          req     = 1'b1;
          req_tgt = S_TITLE;
        end
      end
`endif
    end

    sel_d   = apply ? tgt_q : sel_q;
    blank_d = blank_q;
    if (apply)
      blank_d = (BLANK_FRAMES != 0);
    else if (blank_q && frame_begin && blank_cnt_q == 8'd0)
      blank_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q       <= S_TITLE;
      tgt_q       <= S_TITLE;
      pend_q      <= 1'b0;
      blank_q     <= 1'b0;
      changed_q   <= 1'b0;
      play_q      <= 1'b0;
      blank_cnt_q <= 8'd0;
      go_cnt_q    <= 10'd0;
      btn_q       <= 3'b000;
`ifdef SCREEN_ATTRACT_EN
      idle_q      <= 10'd0;
      att_q       <= 1'b0;
      att_pend_q  <= 1'b0;
`endif
    end else begin
      btn_q     <= btn_now;
      sel_q     <= sel_d;
      blank_q   <= blank_d;
      changed_q <= apply;
      // computed from next-state so play_active has no extra cycle of lag
      play_q    <= (sel_d == S_PLAY) && !blank_d;

      if (req) begin
        pend_q <= 1'b1;
        tgt_q  <= req_tgt;
      end else if (apply) begin
        pend_q <= 1'b0;
      end

      if (apply)
        blank_cnt_q <= BLANK_LOAD;
      else if (blank_q && frame_begin && blank_cnt_q != 8'd0)
        blank_cnt_q <= blank_cnt_q - 8'd1;

      if (apply && tgt_q == S_OVER)
        go_cnt_q <= 10'd0;
      else if (frame_begin && sel_q == S_OVER && !blank_q && go_cnt_q != CNT_MAX)
        go_cnt_q <= go_cnt_q + 10'd1;

`ifdef SCREEN_ATTRACT_EN
      if (rise != 3'b000 || apply)
        idle_q <= 10'd0;
      else if (frame_begin && !pend_q && !blank_q && idle_q != CNT_MAX &&
               (sel_q == S_TITLE || (att_q && (sel_q == S_CTRL1 || sel_q == S_CTRL2))))
        idle_q <= idle_q + 10'd1;

      if (apply)
        att_q <= att_pend_q;
      else if (rise != 3'b000)
        att_q <= 1'b0;

      if (req)
        att_pend_q <= req_att;
      else if (rise != 3'b000)
        att_pend_q <= 1'b0;
`endif
    end
  end

  assign screen_sel     = sel_q;
  assign blank          = blank_q;
  assign screen_changed = changed_q;
  assign play_active    = play_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed scenarios plus random buttons, every cycle compared with a frame-level reference model.
module tb_screen_sequencer;
`ifdef SCREEN_ATTRACT_EN
  localparam int IDLE = 10;
`else
  localparam int IDLE = 600;
`endif
  localparam int BLANK = 2;
  localparam int GO    = 180;

  logic       clk = 1'b0, reset = 1'b1, frame_begin = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_centre = 1'b0, game_over = 1'b0;
  logic [2:0] screen_sel;
  logic       blank, screen_changed, play_active;

  int checks = 0;
  int errors = 0;
  int period = 110;
  int fcnt   = 1;
  bit last_fb;

  // reference model: screen number, owed black frames, pending request
  int m_sel, m_tgt, m_blank_left, m_go;
  bit m_pend, m_changed;
  bit [2:0] m_prev;
`ifdef SCREEN_ATTRACT_EN
  int m_idle;
  bit m_att, m_att_pend;
`endif

  screen_sequencer #(.BLANK_FRAMES(BLANK), .GAMEOVER_FRAMES(GO), .IDLE_FRAMES(IDLE)) dut (
    .clk(clk), .reset(reset), .frame_begin(frame_begin),
    .btn_left(btn_left), .btn_right(btn_right), .btn_centre(btn_centre), .game_over(game_over),
    .screen_sel(screen_sel), .blank(blank), .screen_changed(screen_changed), .play_active(play_active)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_tgt = 0; m_blank_left = 0; m_go = 0;
    m_pend = 0; m_changed = 0; m_prev = 3'b000;
`ifdef SCREEN_ATTRACT_EN
    m_idle = 0; m_att = 0; m_att_pend = 0;
`endif
  endtask

  task automatic model_update();
    bit cr, rr, lr, anyr, o_blank, o_pend, req, applied;
    int o_sel, t;
`ifdef SCREEN_ATTRACT_EN
    bit o_att, ra;
    o_att = m_att;
    ra = 0;
`endif
    cr = btn_centre && !m_prev[2];
    rr = btn_right  && !m_prev[1];
    lr = btn_left   && !m_prev[0];
    anyr = cr || rr || lr;
    o_blank = m_blank_left > 0;
    o_pend = m_pend;
    o_sel = m_sel;
    req = 0;
    t = 0;
    if (!o_pend && !o_blank) begin
      case (o_sel)
        0: if (cr) begin req = 1; t = 1; end
        1: if (cr || rr || lr) begin req = 1; t = cr ? 3 : (rr ? 2 : 0); end
        2: if (cr || lr) begin req = 1; t = cr ? 3 : 1; end
        3: if (game_over) begin req = 1; t = 4; end
        default: if (cr || m_go >= GO) begin req = 1; t = 0; end
      endcase
`ifdef SCREEN_ATTRACT_EN
      if (!req && !anyr && m_idle >= IDLE) begin
        if (o_sel == 0) begin req = 1; t = 1; ra = 1; end
        else if (o_att && (o_sel == 1 || o_sel == 2)) begin req = 1; t = 0; end
      end
`endif
    end
    applied = o_pend && frame_begin;
    m_changed = applied;
    if (frame_begin && o_sel == 4 && !o_blank) m_go = (m_go < 1023) ? m_go + 1 : 1023;
    if (applied && m_tgt == 4) m_go = 0;
    if (applied) begin
      m_sel = m_tgt;
      m_pend = 0;
      m_blank_left = BLANK;
    end else if (frame_begin && o_blank) begin
      m_blank_left--;
    end
`ifdef SCREEN_ATTRACT_EN
    if (applied) m_att = m_att_pend;
    else if (anyr) m_att = 0;
    if (anyr || applied) m_idle = 0;
    else if (frame_begin && !o_pend && !o_blank && m_idle < 1023 &&
             (o_sel == 0 || (o_att && (o_sel == 1 || o_sel == 2)))) m_idle++;
    if (req) m_att_pend = ra;
    else if (anyr) m_att_pend = 0;
`endif
    if (req) begin
      m_pend = 1;
      m_tgt = t;
    end
    m_prev = {btn_centre, btn_right, btn_left};
  endtask

  task automatic tick();
    frame_begin = (fcnt == 0);
    @(posedge clk);
    last_fb = frame_begin;
    model_update();
    fcnt = (fcnt + 1 >= period) ? 0 : fcnt + 1;
    #1;
    chk("screen_sel", screen_sel, m_sel);
    chk("blank", blank, m_blank_left > 0);
    chk("screen_changed", screen_changed, m_changed);
    chk("play_active", play_active, (m_sel == 3) && (m_blank_left == 0));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_screen_sel", screen_sel, 0);
    chk("rst_blank", blank, 0);
    chk("rst_screen_changed", screen_changed, 0);
    chk("rst_play_active", play_active, 0);
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_change(input int budget, output int ticks, output int fbs);
    ticks = 0;
    fbs = 0;
    do begin
      tick();
      ticks++;
      if (last_fb) fbs++;
    end while (screen_changed !== 1'b1 && ticks < budget);
    chk("change_seen", screen_changed, 1);
  endtask

  task automatic wait_blank(input int budget, output int ticks);
    ticks = 0;
    while (blank !== 1'b0 && ticks < budget) begin
      tick();
      ticks++;
    end
    chk("blank_cleared", blank, 0);
  endtask

  task automatic run_frames(input int n);
    int f = 0;
    int b = 0;
    while (f < n && b < n * 200) begin
      tick();
      b++;
      if (last_fb) f++;
    end
  endtask

  task automatic align_to(input int k);
    int n = 0;
    while (fcnt != k && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic press_centre();
    int t, f;
    btn_centre = 1'b1;
    wait_change(2000, t, f);
    btn_centre = 1'b0;
    wait_blank(2000, t);
  endtask

  initial begin
    int t, f, n;
    model_reset();
    do_reset(3);

    // centre at frame cycle 100 -> CTRL1 at next frame_begin, then two black frames
    period = 110;
    fcnt = 1;
    align_to(100);
    btn_centre = 1'b1;
    wait_change(400, t, f);
    btn_centre = 1'b0;
    chk("title_to_ctrl1_ticks", t, period - 100 + 1);
    chk("ctrl1_sel", screen_sel, 1);
    chk("ctrl1_blank_on", blank, 1);
    wait_blank(1000, t);
    chk("blank_len_ticks", t, BLANK * period);

    // right+left together -> CTRL2; rises during blank dropped
    period = int'($urandom_range(12, 30));
    btn_right = 1'b1;
    btn_left = 1'b1;
    wait_change(200, t, f);
    btn_right = 1'b0;
    btn_left = 1'b0;
    chk("ctrl2_sel", screen_sel, 2);
    btn_centre = 1'b1;
    btn_right = 1'b1;
    tick();
    btn_centre = 1'b0;
    btn_right = 1'b0;
    wait_blank(200, t);
    run_frames(2);
    chk("dropped_during_blank", screen_sel, 2);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    run_frames(2);
    chk("game_over_ignored", screen_sel, 2);

    // PLAY, buttons ignored, game_over -> OVER
    btn_centre = 1'b1;
    wait_change(200, t, f);
    btn_centre = 1'b0;
    chk("play_sel", screen_sel, 3);
    chk("play_blanked", play_active, 0);
    wait_blank(200, t);
    chk("play_active_on", play_active, 1);
    repeat (60) begin
      btn_left = 1'($urandom_range(0, 1));
      btn_right = 1'($urandom_range(0, 1));
      btn_centre = 1'($urandom_range(0, 1));
      tick();
    end
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_centre = 1'b0;
    tick();
    chk("play_buttons_ignored", screen_sel, 3);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    wait_change(200, t, f);
    chk("over_sel", screen_sel, 4);
    chk("over_play_off", play_active, 0);

    // OVER timeout, then OVER with centre at frame 50
    wait_blank(200, t);
    wait_change(8000, t, f);
    chk("over_timeout_frames", f, GO + 1);
    chk("over_timeout_sel", screen_sel, 0);
    wait_blank(200, t);
    press_centre();
    press_centre();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    wait_change(200, t, f);
    wait_blank(200, t);
    run_frames(50);
    btn_centre = 1'b1;
    wait_change(200, t, f);
    btn_centre = 1'b0;
    chk("over_centre_frames", f, 1);
    chk("over_centre_sel", screen_sel, 0);

    // accept coinciding with frame_begin applies one frame later
    wait_blank(200, t);
    align_to(0);
    btn_centre = 1'b1;
    tick();
    chk("same_cycle_no_change", screen_changed, 0);
    chk("same_cycle_sel", screen_sel, 0);
    wait_change(200, t, f);
    btn_centre = 1'b0;
    chk("same_cycle_ticks", t, period);
    chk("same_cycle_ctrl1", screen_sel, 1);
    tick();
    tick();
    chk("blank_before_reset", blank, 1);
    do_reset(2);

    // pending request does not survive reset
    align_to(3);
    btn_centre = 1'b1;
    tick();
    btn_centre = 1'b0;
    do_reset(2);
    run_frames(3);
    chk("pending_killed_by_reset", screen_sel, 0);

    // random traffic against the model
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 7) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 7) == 0) btn_centre = ~btn_centre;
      game_over = ($urandom_range(0, 40) == 0);
      tick();
    end
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_centre = 1'b0;
    game_over = 1'b0;
    do_reset(2);

`ifdef SCREEN_ATTRACT_EN
    wait_change(IDLE * 80, t, f);
    chk("attract_enter_frames", f, IDLE + 1);
    chk("attract_enter_sel", screen_sel, 1);
    wait_change(IDLE * 120, t, f);
    chk("attract_return_frames", f, BLANK + IDLE + 1);
    chk("attract_return_sel", screen_sel, 0);
`else
    n = 0;
    f = 0;
    while (f < 1000) begin
      tick();
      if (last_fb) f++;
      if (screen_changed) n++;
    end
    chk("title_idle_changes", n, 0);
    chk("title_idle_sel", screen_sel, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Frame-synchronous controller that selects which full-screen painter drives the 96x64 OLED: title, control screens 1/2, play field or game-over.
- Sits between the debounced pushbuttons and the screen painter mux. Outputs a screen select, a blank-override flag and a play-enable.
- Screen switches only on frame boundaries, so the display never tears mid-frame.

Parameters:
- BLANK_FRAMES, 2: whole frames of forced black after every screen switch; 0 disables blanking; legal range 0..255.
- GAMEOVER_FRAMES, 180: frames spent on game-over before automatic return to title; legal range 1..1023.
- IDLE_FRAMES, 600: title inactivity timeout, in frames (used only with the optional feature); legal range 1..1023.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_begin  in  1  one-cycle pulse at the start of each OLED frame
- btn_left  in  1  debounced level, active-high
- btn_right  in  1  debounced level, active-high
- btn_centre  in  1  debounced level, active-high
- game_over  in  1  one-cycle pulse from the game logic
- screen_sel  out  3  0=TITLE, 1=CTRL1, 2=CTRL2, 3=PLAY, 4=OVER
- blank  out  1  painter mux forces BLACK while high
- screen_changed  out  1  one-cycle pulse on the cycle screen_sel updates
- play_active  out  1  high when screen_sel==PLAY and blank==0

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset values:
  - screen_sel=0 (TITLE); blank=0; screen_changed=0; play_active=0.
  - Internal pending=0, target=0; all counters 0; button history registers 0.
  - Reset asserted mid-operation (blanking, pending or counting) returns to TITLE immediately. No pending request survives.
- Edge detect:
  - rise_x = btn_x & ~btn_x_q, with btn_x_q registered every cycle.
  - A held button produces exactly one rise.
- Request acceptance:
  - Accepted only when pending==0 and blank==0. Rises at other times are dropped, not queued.
  - Simultaneous rises: priority centre > right > left.
- Transitions (current screen_sel -> target):
  - TITLE: centre -> CTRL1.
  - CTRL1: centre -> PLAY; right -> CTRL2; left -> TITLE.
  - CTRL2: centre -> PLAY; left -> CTRL1; right ignored.
  - PLAY: buttons ignored; game_over -> OVER.
  - OVER: centre -> TITLE; game-over timer expiry -> TITLE.
  - game_over is ignored outside PLAY.
- Apply phase:
  - An accepted request sets pending=1 and latches target. Cycle 0 is the accept cycle.
  - On the first frame_begin strictly after the accept cycle: screen_sel<=target, pending<=0, screen_changed=1 for that cycle.
  - A frame_begin coinciding with the accept cycle does not apply the request; it applies on the following frame_begin.
  - Worst-case latency is one frame plus one cycle.
- Blanking:
  - On apply, if BLANK_FRAMES>0: blank<=1 and blank_cnt<=BLANK_FRAMES-1.
  - Each later frame_begin: if blank_cnt==0 then blank<=0, else decrement.
  - blank is therefore high for exactly BLANK_FRAMES full frames.
  - With BLANK_FRAMES=0, blank stays 0.
- Game-over timer:
  - Cleared on entry to OVER.
  - Increments on frame_begin while screen_sel==OVER and blank==0.
  - When it reaches GAMEOVER_FRAMES it raises a TITLE request, subject to the acceptance rules.
  - A centre rise on the same cycle wins with the same target; only one request is raised.
- play_active is registered and combinationally equal to (screen_sel==3 && !blank); no extra cycle of lag.
- Counters saturate and never wrap. Width is 10 bits for frame timers, 8 bits for blank_cnt.

Optional Feature:
- Macro: SCREEN_ATTRACT_EN.
- Defined:
  - An idle counter increments on frame_begin while screen_sel==TITLE, pending==0 and blank==0.
  - It clears on any button rise and on leaving TITLE.
  - On reaching IDLE_FRAMES it raises a request to CTRL1 (attract mode).
  - While in CTRL1 or CTRL2 reached this way, the same timeout with no rises returns to TITLE.
- Undefined: no idle counter; TITLE exits only on a centre rise. Logic and ports are otherwise identical.

Test Plan:
- Reset release, then a centre pulse at frame cycle 100 -> screen_sel 0->1 at the next frame_begin; screen_changed pulses once; blank high for 2 frames, then low.
- In CTRL1, right and left rise on the same cycle -> target CTRL2 (right wins). A second right during blank is dropped; screen_sel stays 2.
- Enter PLAY with centre; once blank clears -> play_active=1. Button rises have no effect. A game_over pulse -> OVER at the next frame_begin and play_active=0.
- In OVER, send no input -> TITLE request after 180 unblanked frames, applied at frame 181. Repeat with a centre rise at frame 50 -> TITLE at frame 51.
- Request accepted on the same cycle as frame_begin -> no change at that frame; applied at the following frame_begin. Assert reset during blank -> screen_sel=0, blank=0 immediately.
- With SCREEN_ATTRACT_EN and IDLE_FRAMES=10 -> TITLE auto-advances to CTRL1 after 10 idle frames, then returns after 10 more. Without the macro -> TITLE persists for 1000 frames.
